shift_sequencer: RTL and testbench

- Command-driven controller for the 8-bit universal shift register (ports d, l, sh, shl, si, out).
- Accepts one command at a time over a valid/ready handshake: load, shift right, shift left or rotate right, by N steps.
- Drives the register's control pins cycle by cycle and guarantees at most one of l/sh/shl is high in any cycle.
- Returns the final register contents with a done pulse; sits between the top-level command source and the shift_register instance.

---
 rtl/shift_sequencer_pkg.sv | 24 ++
 rtl/shift_sequencer_step_counter.sv | 32 +++
 rtl/shift_sequencer.sv | 154 +++++++++++++++
 tb/tb_shift_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared opcodes, state encoding and default sizes for the shift-register command sequencer.
package shift_sequencer_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 4;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_ROR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_LOAD    = 2'b01,
        S_SHIFT   = 2'b10,
        S_CAPTURE = 2'b11
    } state_t;

    // Ops that move data toward the LSB use the register's sh pin.
    function automatic logic uses_sh(input logic [1:0] op);
        return (op == OP_SHR) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/shift_sequencer_step_counter.sv
// Loadable down-counter of remaining shift steps; last flags the final step.
module step_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    logic [CNT_W-1:0] count_r;

    // Step counter register: load wins over decrement.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_val;
        end else if (dec) begin
            count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign last  = (count_r == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven controller for an 8-bit universal shift register: load / shift / rotate by N,
// Moore-decoded control pins, result capture with a done pulse.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_si,
    input  logic             cmd_abort,
    input  logic [WIDTH-1:0] reg_out,
    output logic [WIDTH-1:0] reg_d,
    output logic             reg_l,
    output logic             reg_sh,
    output logic             reg_shl,
    output logic             reg_si,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [WIDTH-1:0] result
);

    state_t           state_r, state_s;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] data_r;
    logic             si_r;
    logic             abort_seen_r;
    logic             ready_r;
    logic             done_r;
    logic             aborted_r;
    logic [WIDTH-1:0] result_r;
    logic             accept_s;
    logic             last_s;
    logic [CNT_W-1:0] count_s;

    assign accept_s = cmd_valid & ready_r;

    step_counter #(.CNT_W(CNT_W)) u_step_counter (
        .clock    (clock),
        .resetn   (resetn),
        .load     (accept_s),
        .load_val (cmd_count),
        .dec      (state_r == S_SHIFT),
        .count    (count_s),
        .last     (last_s)
    );

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    if (cmd_op == OP_LOAD)        state_s = S_LOAD;
                    else if (cmd_count == '0)     state_s = S_CAPTURE;
                    else                          state_s = S_SHIFT;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_LOAD:    state_s = S_CAPTURE;
            S_SHIFT: begin
                if (last_s || cmd_abort) state_s = S_CAPTURE;
                else                     state_s = S_SHIFT;
            end
            S_CAPTURE: state_s = S_IDLE;
            default:   state_s = S_IDLE;
        endcase
    end

    // Register control pins; rotate feeds the register's own LSB back to si.
    always_comb begin
        reg_d   = '0;
        reg_l   = 1'b0;
        reg_sh  = 1'b0;
        reg_shl = 1'b0;
        reg_si  = 1'b0;
        case (state_r)
            S_LOAD: begin
                reg_l = 1'b1;
                reg_d = data_r;
            end
            S_SHIFT: begin
                reg_sh  = uses_sh(op_r);
                reg_shl = (op_r == OP_SHL);
                reg_si  = (op_r == OP_ROR) ? reg_out[0] : si_r;
            end
            default: begin
                reg_d = '0;
            end
        endcase
    end

    // State register; ready is 0 in reset and tracks IDLE from the first edge after release.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r <= S_IDLE;
            ready_r <= 1'b0;
        end else begin
            state_r <= state_s;
            ready_r <= (state_s == S_IDLE);
        end
    end

    // Operand latch and abort tracking.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            op_r         <= 2'b00;
            data_r       <= '0;
            si_r         <= 1'b0;
            abort_seen_r <= 1'b0;
        end else if (accept_s) begin
            op_r         <= cmd_op;
            data_r       <= cmd_data;
            si_r         <= cmd_si;
            abort_seen_r <= 1'b0;
        end else if ((state_r == S_SHIFT) && cmd_abort) begin
            abort_seen_r <= 1'b1;
        end else begin
            abort_seen_r <= abort_seen_r;
        end
    end

    // Completion: capture register value, pulse done with its aborted qualifier.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            result_r  <= '0;
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
        end else if (state_r == S_CAPTURE) begin
            result_r  <= reg_out;
            done_r    <= 1'b1;
            aborted_r <= abort_seen_r;
        end else begin
            result_r  <= result_r;
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
        end
    end

    assign cmd_ready = ready_r;
    assign busy      = (state_r != S_IDLE);
    assign done      = done_r;
    assign aborted   = aborted_r;
    assign result    = result_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench: directed scenarios then randomized commands against a behavioural model.
module tb_shift_sequencer;
    import shift_sequencer_pkg::*;

    logic       clock = 1'b0;
    logic       resetn;
    logic       cmd_valid, cmd_ready, cmd_si, cmd_abort;
    logic [1:0] cmd_op;
    logic [3:0] cmd_count;
    logic [7:0] cmd_data, reg_out, reg_d, result;
    logic       reg_l, reg_sh, reg_shl, reg_si, busy, done, aborted;

    int checks = 0;
    int errors = 0;

    shift_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
        .clock(clock), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_data(cmd_data), .cmd_si(cmd_si),
        .cmd_abort(cmd_abort), .reg_out(reg_out), .reg_d(reg_d), .reg_l(reg_l),
        .reg_sh(reg_sh), .reg_shl(reg_shl), .reg_si(reg_si), .busy(busy), .done(done),
        .aborted(aborted), .result(result)
    );

    always #5 clock = ~clock;

    // External universal shift register driven by the sequencer.
    logic [7:0] reg_q = 8'h00;
    always @(posedge clock) begin
        if (reg_l)        reg_q <= reg_d;
        else if (reg_sh)  reg_q <= {reg_si, reg_q[7:1]};
        else if (reg_shl) reg_q <= {reg_q[6:0], reg_si};
        else              reg_q <= reg_q;
    end
    assign reg_out = reg_q;

    // Pin monitor: pulse totals and protocol violations.
    logic [1:0] op_cur = 2'b00;
    logic       si_cur = 1'b0;
    logic [7:0] data_cur = 8'h00;
    int l_tot = 0, sh_tot = 0, shl_tot = 0, viol_tot = 0;
    always @(negedge clock) begin
        if (int'(reg_l) + int'(reg_sh) + int'(reg_shl) > 1) viol_tot++;
        if (reg_l) begin
            l_tot++;
            if (reg_d !== data_cur) viol_tot++;
        end
        if (reg_sh) begin
            sh_tot++;
            if (reg_si !== ((op_cur == OP_ROR) ? reg_q[0] : si_cur)) viol_tot++;
        end
        if (reg_shl) begin
            shl_tot++;
            if (reg_si !== si_cur) viol_tot++;
        end
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_apply(input logic [7:0] v, input logic [1:0] op,
                                             input int n, input logic si, input logic [7:0] data);
        int r;
        if (op == OP_LOAD) return data;
        r = int'(v);
        for (int i = 0; i < n; i++) begin
            case (op)
                OP_SHR:  r = r / 2 + (si ? 128 : 0);
                OP_SHL:  r = (r * 2) % 256 + (si ? 1 : 0);
                OP_ROR:  r = r / 2 + ((r % 2) * 128);
                default: r = r;
            endcase
        end
        return 8'(r);
    endfunction

    logic [7:0] model_val = 8'h00;

    task automatic run_cmd(input logic [1:0] op, input logic [3:0] cnt, input logic [7:0] data,
                           input logic si, input int abort_at, input bit hold);
        int n, shifts, lat, bl, bs, bsl, bv;
        logic [7:0] exp_res;
        bit exp_ab, got_done;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        check_value("ready_at_issue", cmd_ready, 1);
        if (op == OP_LOAD)                          shifts = 0;
        else if (abort_at != 0 && abort_at <= cnt)  shifts = abort_at;
        else                                        shifts = cnt;
        exp_ab  = (op != OP_LOAD) && (abort_at != 0) && (abort_at <= cnt);
        exp_res = ref_apply(model_val, op, shifts, si, data);
        lat     = (op == OP_LOAD) ? 2 : shifts + 1;
        op_cur = op; si_cur = si; data_cur = data;
        bl = l_tot; bs = sh_tot; bsl = shl_tot; bv = viol_tot;
        cmd_valid = 1'b1; cmd_op = op; cmd_count = cnt; cmd_data = data; cmd_si = si;
        @(posedge clock);
        #1;
        if (hold) begin
            cmd_op = OP_LOAD; cmd_data = 8'h33; cmd_count = 4'd7;
        end else begin
            cmd_valid = 1'b0;
        end
        got_done = 1'b0;
        for (int k = 1; k <= 40 && !got_done; k++) begin
            @(negedge clock);
            cmd_abort = (k == abort_at);
            if (done) begin
                got_done = 1'b1;
                check_value("latency", k - 1, lat);
            end
        end
        cmd_abort = 1'b0;
        check_value("done_seen", got_done, 1);
        check_value("result", result, exp_res);
        check_value("aborted", aborted, exp_ab);
        check_value("busy_at_done", busy, 0);
        check_value("l_pulses", l_tot - bl, (op == OP_LOAD) ? 1 : 0);
        check_value("sh_pulses", sh_tot - bs, (op == OP_SHR || op == OP_ROR) ? shifts : 0);
        check_value("shl_pulses", shl_tot - bsl, (op == OP_SHL) ? shifts : 0);
        check_value("pin_protocol", viol_tot - bv, 0);
        model_val = exp_res;
    endtask

    initial begin
        int dn;
        logic [1:0] rop;
        logic [3:0] rcnt;
        int rab;
        resetn = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_count = 4'd0;
        cmd_data = 8'h00; cmd_si = 1'b0; cmd_abort = 1'b0;
        repeat (2) @(negedge clock);
        check_value("reset_outputs", {reg_d, reg_l, reg_sh, reg_shl, reg_si, busy, done, aborted, result}, 0);
        check_value("reset_ready", cmd_ready, 0);
        resetn = 1'b1;
        @(negedge clock);
        check_value("ready_after_reset", cmd_ready, 1);

        run_cmd(OP_LOAD, 4'd0, 8'h49, 1'b0, 0, 1'b0);
        check_value("tp_load", result, 8'h49);
        run_cmd(OP_SHR, 4'd3, 8'h00, 1'b1, 0, 1'b0);
        check_value("tp_shr3", result, 8'hE9);
        run_cmd(OP_SHL, 4'd2, 8'h00, 1'b0, 0, 1'b0);
        check_value("tp_shl2", result, 8'hA4);
        run_cmd(OP_ROR, 4'd4, 8'h00, 1'b0, 0, 1'b0);
        check_value("tp_ror4", result, 8'h4A);
        run_cmd(OP_SHR, 4'd0, 8'h00, 1'b1, 0, 1'b0);
        check_value("tp_shr0", result, 8'h4A);
        run_cmd(OP_SHL, 4'd3, 8'h00, 1'b1, 0, 1'b1);
        run_cmd(OP_LOAD, 4'd7, 8'h33, 1'b0, 0, 1'b0);
        check_value("tp_held_load", result, 8'h33);
        run_cmd(OP_LOAD, 4'd0, 8'hFF, 1'b0, 0, 1'b0);
        run_cmd(OP_SHR, 4'd8, 8'h00, 1'b0, 3, 1'b0);
        check_value("tp_abort_result", result, 8'h1F);
        check_value("tp_abort_ready", cmd_ready, 1);

        // Reset in the middle of SHR by 5: one shift lands before reset.
        op_cur = OP_SHR; si_cur = 1'b1;
        cmd_valid = 1'b1; cmd_op = OP_SHR; cmd_count = 4'd5; cmd_si = 1'b1;
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        check_value("rst_sh_drop", reg_sh, 0);
        check_value("rst_busy_drop", busy, 0);
        check_value("rst_ready_low", cmd_ready, 0);
        model_val = ref_apply(model_val, OP_SHR, 1, 1'b1, 8'h00);
        @(negedge clock);
        resetn = 1'b1;
        dn = 0;
        repeat (6) begin
            @(negedge clock);
            if (done) dn++;
        end
        check_value("rst_no_done", dn, 0);
        check_value("rst_ready_back", cmd_ready, 1);
        check_value("rst_reg_state", reg_out, model_val);
        run_cmd(OP_LOAD, 4'd0, 8'h5A, 1'b0, 0, 1'b0);
        check_value("tp_load_after_rst", result, 8'h5A);

        for (int i = 0; i < 40; i++) begin
            rop  = 2'($urandom_range(0, 3));
            rcnt = 4'($urandom_range(0, 15));
            rab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, int'(rcnt) + 2)) : 0;
            run_cmd(rop, rcnt, 8'($urandom), 1'($urandom), rab, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
